clock_rate_meter: RTL and testbench

Measures the period of a slow, free-running square wave against the system clock. The square wave is typically a divided clock from the FPGA demo's clock divider or an external tick. The block reports the full period in `clk_in` cycles, plus the equivalent divider setting (half-period). It also flags lock and stall conditions. It sits on the FPGA demo's status path so firmware and testbenches can confirm that a divided clock runs at the programmed rate.

---
 rtl/clock_rate_meter.sv | 168 ++++++++++++++++
 tb/tb_clock_rate_meter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_rate_meter.sv
// clock_rate_meter: measures the full period of a slow square wave in clk_in cycles,
// with lock/stall flags. Define CLOCK_METER_AVG_EN to report the mean of every 4 samples.
module clock_rate_meter #(
  parameter int unsigned     WIDTH   = 32,
  parameter longint unsigned TIMEOUT = 50_000_000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] divisor_est,
  output logic             period_valid,
  output logic             locked,
  output logic             stalled
);

  // state     | meaning
  // ARM       | wait for a settled low input before accepting edges
  // WAIT_EDGE | wait for the first rising edge, which starts a measurement
  // MEASURE   | count cycles until the next rise (report) or the timeout (stall)
  typedef enum logic [1:0] {ARM, WAIT_EDGE, MEASURE} state_t;

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic [1:0]       r_fill;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_prev;
  logic             r_valid;
  logic             r_locked;
  logic             r_stalled;

  logic             w_rise;
  logic             w_start;
  logic             w_sample_en;
  logic             w_timeout;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_rep_en;
  logic [WIDTH-1:0] w_rep_val;
  logic [WIDTH-1:0] w_rep_div;
  logic [WIDTH-1:0] w_diff;

  assign w_rise    = r_s2 & ~r_s3;
  assign w_cnt_inc = r_cnt + WIDTH'(1);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_fill <= 2'b00;
    end else begin
      r_s1   <= sig_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_fill <= {r_fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_state <= ARM;
    else       r_state <= w_state_nxt;
  end

  // ARM also waits for the synchroniser to fill after reset; otherwise its zero
  // reset contents would make an input already high at release look like a fresh edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sample_en = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ARM: begin
        if (r_fill[1] && !r_s2) w_state_nxt = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (w_rise) begin
          w_start     = 1'b1;
          w_state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_sample_en = 1'b1;
        end else if (w_cnt_inc == TIMEOUT_W) begin
          w_timeout   = 1'b1;
          w_state_nxt = ARM;
        end
      end
      default: w_state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_start || w_sample_en || w_timeout) begin
      r_cnt <= '0;
    end else if (r_state == MEASURE) begin
      r_cnt <= w_cnt_inc;
    end
  end

`ifdef CLOCK_METER_AVG_EN
  logic [WIDTH+1:0] r_sum;
  logic [1:0]       r_nsamp;
  logic [WIDTH+1:0] w_sum_nxt;

  assign w_sum_nxt = r_sum + (WIDTH+2)'(w_cnt_inc);
  assign w_rep_en  = w_sample_en && (r_nsamp == 2'd3);
  assign w_rep_val = WIDTH'(w_sum_nxt >> 2);
  assign w_rep_div = WIDTH'(w_sum_nxt >> 3);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sum   <= '0;
      r_nsamp <= 2'd0;
    end else if (w_timeout) begin
      r_sum   <= '0;
      r_nsamp <= 2'd0;
    end else if (w_sample_en) begin
      r_sum   <= (r_nsamp == 2'd3) ? '0 : w_sum_nxt;
      r_nsamp <= r_nsamp + 2'd1;
    end
  end
`else
  assign w_rep_en  = w_sample_en;
  assign w_rep_val = w_cnt_inc;
  assign w_rep_div = w_cnt_inc >> 1;
`endif

  assign w_diff = (w_rep_val >= r_prev) ? (w_rep_val - r_prev) : (r_prev - w_rep_val);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_period  <= '0;
      r_div     <= '0;
      r_prev    <= '0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_stalled <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_rep_en) begin
        r_period  <= w_rep_val;
        r_div     <= w_rep_div;
        r_prev    <= w_rep_val;
        r_valid   <= 1'b1;
        r_stalled <= 1'b0;
        r_locked  <= (w_diff <= WIDTH'(1));
      end else if (w_timeout) begin
        r_stalled <= 1'b1;
        r_locked  <= 1'b0;
      end
    end
  end

  assign period       = r_period;
  assign divisor_est  = r_div;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign stalled      = r_stalled;

endmodule

// File: tb/tb_clock_rate_meter.sv
// tb_clock_rate_meter: directed + randomized checks of clock_rate_meter against an
// edge-list reference model (default build, TIMEOUT = 100).
module tb_clock_rate_meter;
  localparam int WIDTH = 16;
  localparam int TO    = 100;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] divisor_est;
  logic             period_valid;
  logic             locked;
  logic             stalled;

  clock_rate_meter #(.WIDTH(WIDTH), .TIMEOUT(TO)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .sig_in      (sig_in),
    .period      (period),
    .divisor_est (divisor_est),
    .period_valid(period_valid),
    .locked      (locked),
    .stalled     (stalled)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int at;
    int per;
    int dv;
    int lk;
  } rep_t;

  rep_t obs_q[$];
  rep_t exp_q[$];
  int   rises[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_chk = 0;
  logic prev_sig = 1'b0;

  function automatic rep_t mk(input int a, input int b, input int c, input int d);
    rep_t r;
    r.at  = a;
    r.per = b;
    r.dv  = c;
    r.lk  = d;
    return r;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // At the negedge after edge cyc, sig_in is the value the next edge will sample.
  always @(negedge clk_in) begin
    if (sig_in && !prev_sig) rises.push_back(cyc + 1);
    if (period_valid) obs_q.push_back(mk(cyc, int'(period), int'(divisor_est), int'(locked)));
    prev_sig <= sig_in;
  end

  // Reference: consecutive accepted rises k0,k1 give period k1-k0 reported at edge k1+2;
  // a gap longer than TO means a stall, and the later rise only restarts measurement.
  function automatic void build_expected(input int upto);
    int  last;
    int  prev;
    int  p;
    int  d;
    bit  started;
    exp_q.delete();
    started = 0;
    prev    = 0;
    last    = 0;
    foreach (rises[i]) begin
      if (!started) begin
        started = 1;
        last    = rises[i];
      end else begin
        p    = rises[i] - last;
        last = rises[i];
        if (p <= TO) begin
          d = (p > prev) ? p - prev : prev - p;
          if (rises[i] + 2 <= upto) exp_q.push_back(mk(rises[i] + 2, p, p / 2, (d <= 1) ? 1 : 0));
          prev = p;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_reports(input string tag);
    build_expected(cyc - 1);
    chk({tag, " count"}, obs_q.size(), exp_q.size());
    for (int i = n_chk; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, " edge"},    obs_q[i].at,  exp_q[i].at);
      chk({tag, " period"},  obs_q[i].per, exp_q[i].per);
      chk({tag, " divisor"}, obs_q[i].dv,  exp_q[i].dv);
      chk({tag, " locked"},  obs_q[i].lk,  exp_q[i].lk);
    end
    n_chk = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wave(input int hi, input int lo);
    sig_in = 1'b1;
    tick(hi);
    sig_in = 1'b0;
    tick(lo);
  endtask

  task automatic clear_model();
    rises.delete();
    obs_q.delete();
    n_chk = 0;
  endtask

  initial begin
    int hi;
    int lo;
    int p;
    int base;
    int lr;

    reset  = 1'b1;
    sig_in = 1'b0;
    tick(3);
    clear_model();
    reset = 1'b0;
    chk("reset period", period, 0);
    chk("reset divisor", divisor_est, 0);
    chk("reset valid", period_valid, 0);
    chk("reset locked", locked, 0);
    chk("reset stalled", stalled, 0);
    tick(6);

    // steady period 10
    repeat (8) wave(5, 5);
    tick(4);
    check_reports("steady");
    chk("steady reports", obs_q.size(), 7);
    chk("steady period", period, 10);
    chk("steady divisor", divisor_est, 5);
    chk("steady locked", locked, 1);

    // rate change 10 -> 14
    repeat (2) wave(7, 7);
    tick(4);
    check_reports("rate");
    if (obs_q.size() >= 2) begin
      chk("rate first 14 lock", obs_q[obs_q.size() - 2].lk, 0);
      chk("rate second 14 lock", obs_q[obs_q.size() - 1].lk, 1);
    end
    chk("rate period", period, 14);

    // random periods, then a jittering steady rate
    repeat (10) begin
      hi = $urandom_range(1, 8);
      lo = $urandom_range(1, 8);
      wave(hi, lo);
    end
    tick(4);
    check_reports("random");
    base = $urandom_range(8, 30);
    repeat (8) begin
      p  = base + $urandom_range(0, 1);
      hi = p / 2;
      lo = p - hi;
      wave(hi, lo);
    end
    tick(4);
    check_reports("jitter");

    // stall: hold low after a period-10 run
    repeat (4) wave(5, 5);
    lr = rises[rises.size() - 1];
    while (cyc < lr + TO + 1) @(negedge clk_in);
    chk("stall not early", stalled, 0);
    @(negedge clk_in);
    chk("stall flagged", stalled, 1);
    chk("stall locked", locked, 0);
    chk("stall period held", period, 10);
    chk("stall divisor held", divisor_est, 5);
    tick(40);
    check_reports("stall");
    wave(5, 5);
    chk("stall after first rise", stalled, 1);
    wave(5, 5);
    tick(3);
    chk("stall cleared", stalled, 0);
    chk("resume locked", locked, 1);
    check_reports("resume");

    // reset in the middle of a period
    repeat (3) wave(5, 5);
    sig_in = 1'b1;
    tick(5);
    sig_in = 1'b0;
    tick(2);
    reset = 1'b1;
    #1;
    chk("mid reset period", period, 0);
    chk("mid reset divisor", divisor_est, 0);
    chk("mid reset valid", period_valid, 0);
    chk("mid reset locked", locked, 0);
    chk("mid reset stalled", stalled, 0);
    tick(1);
    clear_model();
    reset = 1'b0;
    tick(8);
    wave(5, 5);
    chk("mid reset no early report", obs_q.size(), 0);
    repeat (3) wave(6, 6);
    tick(4);
    check_reports("post reset");
    chk("post reset reports", obs_q.size(), 3);

    // input already high at reset release
    reset  = 1'b1;
    sig_in = 1'b1;
    tick(3);
    clear_model();
    reset = 1'b0;
    tick(12);
    sig_in = 1'b0;
    tick(10);
    repeat (4) wave(10, 10);
    tick(4);
    check_reports("high release");
    chk("high release reports", obs_q.size(), 3);
    if (obs_q.size() > 0) chk("high release first period", obs_q[0].per, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
